// File: rtl/hazard_ctrl_fsm_pkg.sv
// Shared encodings for the pipeline hazard controller.
//   redir_e  : ID redirect code presented on branch_or_jump
//   pc_sel_e : PC source select driven on pc_sel
//   state_e  : hazard FSM states
package hazard_ctrl_fsm_pkg;

  typedef enum logic [1:0] {
    REDIR_SEQ   = 2'b00,
    REDIR_BR_NT = 2'b01,
    REDIR_BR_TK = 2'b10,
    REDIR_JUMP  = 2'b11
  } redir_e;

  typedef enum logic [1:0] {
    PCSEL_PC4    = 2'b00,
    PCSEL_BRANCH = 2'b01,
    PCSEL_JUMP   = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LD_STALL = 2'b01,
    ST_MD_WAIT  = 2'b10,
    ST_FREEZE   = 2'b11
  } state_e;

endpackage

// File: rtl/hazard_ctrl_fsm_stall_counter.sv
// hazard_stall_counter: loadable down-counter with a zero flag, used to
// count the remaining load-use bubbles.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (clears count)
//   load_i      load load_val_i (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one, saturating at zero
//   cnt_o       current count
//   zero_o      count is zero
module hazard_stall_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl_fsm.sv
// hazard_ctrl_fsm: stateful pipeline hazard controller. Handles multi-cycle
// load-use stalls, a mul/div busy interlock, a global freeze on data-memory
// wait and branch/jump redirects. Outputs are decoded combinationally from
// state plus current inputs so a hazard stalls in the cycle it is seen.
//
// States:
//   state       | meaning
//   ST_RUN      | normal issue, redirects honoured
//   ST_LD_STALL | inserting remaining load-use bubbles (counter > 0)
//   ST_MD_WAIT  | ID waits for the mul/div unit
//   ST_FREEZE   | dmem not ready; interrupted state kept in saved_q
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   branch_or_jump               ID redirect code (redir_e)
//   id_ex_mem_read, id_ex_rt     load in EX and its destination
//   if_id_rs, if_id_rt           ID source registers
//   id_uses_md, md_busy          mul/div interlock inputs
//   dmem_wait                    data memory not ready
//   pc_write, if_id_write        front-end enables
//   pc_sel, if_id_flush          redirect controls
//   id_ex_bubble, pipe_freeze    bubble insert / back-end hold
// Optional (macro HAZARD_PERF_CNT_EN): stall_cnt, flush_cnt, freeze_cnt.
module hazard_ctrl_fsm
  import hazard_ctrl_fsm_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W          = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        branch_or_jump,
  input  logic              id_ex_mem_read,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              id_uses_md,
  input  logic              md_busy,
  input  logic              dmem_wait,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [1:0]        pc_sel,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pipe_freeze
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       freeze_cnt
`endif
);

  localparam logic             MULTI_CYC = (LOAD_STALL_CYC > 1);
  localparam logic [CNT_W-1:0] LD_INIT   = CNT_W'(LOAD_STALL_CYC - 1);

  state_e           state_q, state_d, saved_q, saved_d, eff_state;
  logic             hz, md_stall, stall, freeze;
  logic             ld_load, ld_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  hazard_stall_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ld_load),
    .load_val_i (LD_INIT),
    .dec_i      (ld_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    // While frozen (or on the release cycle) act as the interrupted state;
    // this makes the restore take effect the cycle dmem_wait drops.
    eff_state    = (state_q == ST_FREEZE) ? saved_q : state_q;
    hz           = id_ex_mem_read && (id_ex_rt != '0) &&
                   ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    md_stall     = (eff_state == ST_MD_WAIT) ? md_busy : (id_uses_md && md_busy);
    state_d      = state_q;
    saved_d      = saved_q;
    ld_load      = 1'b0;
    ld_dec       = 1'b0;
    stall        = 1'b0;
    freeze       = 1'b0;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    pc_sel       = PCSEL_PC4;
    if_id_flush  = 1'b0;

    if (dmem_wait) begin
      freeze  = 1'b1;
      state_d = ST_FREEZE;
      saved_d = eff_state;
    end else if (eff_state == ST_LD_STALL) begin
      stall   = 1'b1;
      ld_dec  = 1'b1;
      state_d = ((cnt == CNT_W'(1)) || cnt_zero) ? ST_RUN : ST_LD_STALL;
    end else if (hz) begin
      stall = 1'b1;
      if (MULTI_CYC) begin
        ld_load = 1'b1;
        state_d = ST_LD_STALL;
      end else begin
        state_d = ST_RUN;
      end
    end else if (md_stall) begin
      stall   = 1'b1;
      state_d = ST_MD_WAIT;
    end else begin
      state_d     = ST_RUN;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if (eff_state == ST_RUN) begin
        case (redir_e'(branch_or_jump))
          REDIR_BR_TK: begin
            pc_sel      = PCSEL_BRANCH;
            if_id_flush = 1'b1;
          end
          REDIR_JUMP: begin
            pc_sel      = PCSEL_JUMP;
            if_id_flush = 1'b1;
          end
          default: pc_sel = PCSEL_PC4;
        endcase
      end
    end

    id_ex_bubble = stall || if_id_flush;
    pipe_freeze  = freeze;

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      pc_sel       = PCSEL_PC4;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b1;
      pipe_freeze  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      saved_q <= ST_RUN;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall)       stall_cnt  <= stall_cnt + 32'd1;
      if (if_id_flush) flush_cnt  <= flush_cnt + 32'd1;
      if (freeze)      freeze_cnt <= freeze_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_fsm.sv
// Directed bench for hazard_ctrl_fsm with LOAD_STALL_CYC=2. Inputs change
// 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_hazard_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] branch_or_jump;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
  logic       id_uses_md, md_busy, dmem_wait;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;
  logic [1:0] pc_sel;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  // {pc_write, if_id_write, pc_sel, if_id_flush, id_ex_bubble, pipe_freeze}
  localparam logic [6:0] O_IDLE  = 7'b11_00_0_0_0;
  localparam logic [6:0] O_STALL = 7'b00_00_0_1_0;
  localparam logic [6:0] O_BRTK  = 7'b11_01_1_1_0;
  localparam logic [6:0] O_JUMP  = 7'b11_10_1_1_0;
  localparam logic [6:0] O_FRZ   = 7'b00_00_0_0_1;
  localparam logic [6:0] O_RST   = 7'b00_00_0_1_0;

  always #5 clk = ~clk;

  hazard_ctrl_fsm #(.REG_AW(5), .LOAD_STALL_CYC(2), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .branch_or_jump (branch_or_jump),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rt       (id_ex_rt),
    .if_id_rs       (if_id_rs),
    .if_id_rt       (if_id_rt),
    .id_uses_md     (id_uses_md),
    .md_busy        (md_busy),
    .dmem_wait      (dmem_wait),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .pc_sel         (pc_sel),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .pipe_freeze    (pipe_freeze)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .freeze_cnt     (freeze_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_now(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {pc_write, if_id_write, pc_sel, if_id_flush, id_ex_bubble, pipe_freeze};
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    @(negedge clk);
    chk_now(tag, exp);
  endtask

  task automatic ld(input logic rd, input logic [4:0] ert, input logic [4:0] rs,
                    input logic [4:0] rt);
    id_ex_mem_read = rd;
    id_ex_rt       = ert;
    if_id_rs       = rs;
    if_id_rt       = rt;
  endtask

  initial begin
    rst = 1'b1;
    branch_or_jump = 2'b00;
    ld(1'b0, 5'd0, 5'd0, 5'd0);
    id_uses_md = 1'b0;
    md_busy    = 1'b0;
    dmem_wait  = 1'b0;
    #3;
    chk_now("reset_outputs", O_RST);
    tick();
    tick();
    rst = 1'b0;
    chk("run_idle", O_IDLE);

    // load-use via rs: exactly two bubbles, hazard kept during LD_STALL
    tick(); ld(1'b1, 5'd5, 5'd5, 5'd0);
    chk("ld_rs_bubble1", O_STALL);
    tick();
    chk("ld_rs_bubble2", O_STALL);
    tick(); ld(1'b0, 5'd5, 5'd5, 5'd0);
    chk("ld_rs_back_to_run", O_IDLE);

    // $zero destination never stalls
    tick(); ld(1'b1, 5'd0, 5'd0, 5'd0);
    chk("ld_zero_no_stall", O_IDLE);
    // register match without a load never stalls
    tick(); ld(1'b0, 5'd7, 5'd0, 5'd7);
    chk("no_load_no_stall", O_IDLE);
    // load-use via rt
    tick(); ld(1'b1, 5'd7, 5'd3, 5'd7);
    chk("ld_rt_bubble1", O_STALL);
    tick(); ld(1'b0, 5'd7, 5'd3, 5'd7);
    chk("ld_rt_bubble2", O_STALL);
    tick();
    chk("ld_rt_back_to_run", O_IDLE);

    // redirects
    tick(); branch_or_jump = 2'b10;
    chk("br_taken", O_BRTK);
    tick(); branch_or_jump = 2'b00;
    chk("seq_after_br", O_IDLE);
    tick(); branch_or_jump = 2'b11;
    chk("jump", O_JUMP);
    tick(); branch_or_jump = 2'b01;
    chk("br_not_taken", O_IDLE);
    tick(); branch_or_jump = 2'b00;

    // mul/div interlock: 4 busy cycles, release with no extra bubble
    id_uses_md = 1'b1;
    md_busy    = 1'b1;
    chk("md_stall1", O_STALL);
    tick(); chk("md_stall2", O_STALL);
    tick(); chk("md_stall3", O_STALL);
    tick(); chk("md_stall4", O_STALL);
    tick(); md_busy = 1'b0;
    chk("md_release", O_IDLE);
    tick(); id_uses_md = 1'b0;
    chk("md_after", O_IDLE);

    // redirect coinciding with a load-use stall is ignored
    tick(); ld(1'b1, 5'd9, 5'd9, 5'd0); branch_or_jump = 2'b10;
    chk("br_during_ld1", O_STALL);
    tick();
    chk("br_during_ld2", O_STALL);
    tick(); ld(1'b0, 5'd9, 5'd9, 5'd0);
    chk("br_represented", O_BRTK);
    tick(); branch_or_jump = 2'b00;
    chk("idle_after_br", O_IDLE);

    // freeze in the middle of LD_STALL, one bubble left afterwards
    tick(); ld(1'b1, 5'd4, 5'd4, 5'd0);
    chk("frz_ld_bubble1", O_STALL);
    tick(); ld(1'b0, 5'd4, 5'd4, 5'd0); dmem_wait = 1'b1;
    chk("frz_cycle1", O_FRZ);
    tick(); chk("frz_cycle2", O_FRZ);
    tick(); chk("frz_cycle3", O_FRZ);
    tick(); dmem_wait = 1'b0;
    chk("frz_ld_remaining", O_STALL);
    tick(); chk("frz_ld_done", O_IDLE);

    // freeze beats a jump from RUN; the jump is honoured afterwards
    tick(); dmem_wait = 1'b1; branch_or_jump = 2'b11;
    chk("frz_over_jump", O_FRZ);
    tick(); dmem_wait = 1'b0;
    chk("jump_after_frz", O_JUMP);
    tick(); branch_or_jump = 2'b00;
    chk("idle_after_jump", O_IDLE);

    // asynchronous reset while in MD_WAIT
    tick(); id_uses_md = 1'b1; md_busy = 1'b1;
    chk("md_pre_rst1", O_STALL);
    tick(); chk("md_pre_rst2", O_STALL);
    #1; dmem_wait = 1'b1;
    #1; chk_now("frz_pre_rst", O_FRZ);
    #1; rst = 1'b1;
    #1; chk_now("rst_async_outputs", O_RST);
    tick();
    chk_now("rst_held_outputs", O_RST);
    rst = 1'b0; dmem_wait = 1'b0; id_uses_md = 1'b0;
    chk("run_after_rst", O_IDLE);
    tick(); md_busy = 1'b0;
    chk("idle_end", O_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
